systolic_seq: RTL and testbench

SYSTOLIC_SEQ -- requirements
Module: systolic_seq

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_seq_skew_window.sv | 23 ++
 rtl/systolic_seq.sv | 139 +++++++++++++
 tb/tb_systolic_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg : shared types and defaults for the systolic sequencer  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package systolic_pkg;

  localparam int DIM_DEFAULT = 8;
  localparam int BITS_AB     = 8;
  localparam int BITS_C      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_C  = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Two spare bits keep K + 2*DIM - 3 representable for the largest K and DIM.
  function automatic int step_width(input int kw);
    return kw + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_seq_skew_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_window : per-lane feed-valid mask for the skewed operand wave   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module skew_window #(
  parameter int DIM = 8,
  parameter int SW  = 10
) (
  input  logic           en_i,
  input  logic [SW-1:0]  step_i,
  input  logic [SW-1:0]  k_i,
  output logic [DIM-1:0] mask_o
);

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    localparam logic [SW-1:0] c_LANE = SW'(r);
    // Lane r sees its operand stream from step r for exactly K steps.
    assign mask_o[r] = en_i && (step_i >= c_LANE) && ((step_i - c_LANE) < k_i);
  end

endmodule
`default_nettype wire

// File: rtl/systolic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_seq : pass sequencer for a DIM x DIM tpumac systolic array  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DIM = DIM_DEFAULT,
  parameter int KW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KW-1:0]           cfg_k,
  output logic                    busy,
  output logic                    done,
  output logic                    arr_en,
  output logic                    arr_WrEn,
  output logic [$clog2(DIM)-1:0]  c_idx,
  output logic [KW+1:0]           step,
  output logic [DIM-1:0]          a_mask,
  output logic [DIM-1:0]          b_mask,
  output logic                    out_valid
);

  localparam int SW = step_width(KW);
  localparam int CW = $clog2(DIM);
  localparam logic [SW-1:0] c_ROW_LAST = SW'(DIM - 1);
  localparam logic [SW-1:0] c_SKEW     = SW'(2 * DIM - 3);
  localparam logic [CW-1:0] c_IDX_LAST = CW'(DIM - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SW-1:0]   w_k_ext;
  logic [SW-1:0]   w_cmp_last;
  logic [SW-1:0]   w_step;
  logic            w_computing;

  assign w_k_ext     = SW'(k_q);
  assign w_cmp_last  = w_k_ext + c_SKEW;
  assign w_computing = (state_q == ST_COMPUTE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_C;
          cnt_d   = '0;
          k_d     = cfg_k;
        end
      end
      ST_LOAD_C: begin
        if (cnt_q == c_ROW_LAST) begin
          cnt_d   = '0;
          state_d = (k_q != '0) ? ST_COMPUTE : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == w_cmp_last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == c_ROW_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides every transition, including the last cycle of a phase.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  assign w_step    = w_computing ? cnt_q : '0;
  assign step      = w_step;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign arr_en    = (state_q == ST_LOAD_C) || w_computing || (state_q == ST_DRAIN);
  assign arr_WrEn  = (state_q == ST_LOAD_C) || (state_q == ST_DRAIN);
  assign out_valid = (state_q == ST_DRAIN);

  always_comb begin
    c_idx = '0;
    if (state_q == ST_LOAD_C) begin
      c_idx = cnt_q[CW-1:0];
    end else if (state_q == ST_DRAIN) begin
      c_idx = c_IDX_LAST - cnt_q[CW-1:0];
    end
  end

  skew_window #(.DIM(DIM), .SW(SW)) u_a_win (
    .en_i   (w_computing),
    .step_i (w_step),
    .k_i    (w_k_ext),
    .mask_o (a_mask)
  );

  skew_window #(.DIM(DIM), .SW(SW)) u_b_win (
    .en_i   (w_computing),
    .step_i (w_step),
    .k_i    (w_k_ext),
    .mask_o (b_mask)
  );

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_systolic_seq : self-checking bench for systolic_seq at DIM=4      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_systolic_seq;

  localparam int DIM = 4;
  localparam int KW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [KW-1:0]   cfg_k;
  logic            busy, done, arr_en, arr_WrEn, out_valid;
  logic [1:0]      c_idx;
  logic [KW+1:0]   step;
  logic [DIM-1:0]  a_mask, b_mask;

  int checks = 0;
  int errors = 0;

  systolic_seq #(.DIM(DIM), .KW(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_k     (cfg_k),
    .busy      (busy),
    .done      (done),
    .arr_en    (arr_en),
    .arr_WrEn  (arr_WrEn),
    .c_idx     (c_idx),
    .step      (step),
    .a_mask    (a_mask),
    .b_mask    (b_mask),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           busy;
    logic           done;
    logic           en;
    logic           wren;
    logic           ov;
    logic [1:0]     cidx;
    logic [KW+1:0]  step;
    logic [DIM-1:0] am;
    logic [DIM-1:0] bm;
  } obs_t;

  typedef struct {
    int             k;
    int             cyc;
    logic           busy;
    logic           done;
    logic [1:0]     cidx;
    logic [KW+1:0]  step;
    logic [DIM-1:0] am;
  } vec_t;

  // Expected observation n cycles after the start edge (n=1 is the first LOAD_C cycle).
  function automatic obs_t model(int k, int n);
    obs_t o;
    int   len;
    int   s;
    o   = '0;
    len = (k > 0) ? k + 2 * DIM - 2 : 0;
    if (n >= 1 && n <= DIM) begin
      o.busy = 1'b1; o.en = 1'b1; o.wren = 1'b1;
      o.cidx = 2'(n - 1);
    end else if (n > DIM && n <= DIM + len) begin
      s = n - DIM - 1;
      o.busy = 1'b1; o.en = 1'b1;
      o.step = (KW+2)'(s);
      for (int r = 0; r < DIM; r++) begin
        if (s >= r && (s - r) < k) o.am[r] = 1'b1;
      end
      o.bm = o.am;
    end else if (n > DIM + len && n <= 2 * DIM + len) begin
      o.busy = 1'b1; o.en = 1'b1; o.wren = 1'b1; o.ov = 1'b1;
      o.cidx = 2'(DIM - 1 - (n - DIM - len - 1));
    end else if (n == 2 * DIM + len + 1) begin
      o.busy = 1'b1; o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.en = arr_en; o.wren = arr_WrEn;
    o.ov = out_valid; o.cidx = c_idx; o.step = step; o.am = a_mask; o.bm = b_mask;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Returns at the falling edge inside the first LOAD_C cycle.
  task automatic start_pass(input int k);
    @(negedge clk);
    start = 1'b1;
    cfg_k = KW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    obs_t exp_o;
    int   k, len, n_ab, m;
    logic seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_k = '0;
    #12;
    check("reset_state", 64'(sample()), 64'(obs_t'('0)));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(sample()), 64'(obs_t'('0)));

    // Hand-computed points from the K=3 and K=0 timelines, plus a wide K.
    vecs.push_back('{3,   1,   1'b1, 1'b0, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{3,   4,   1'b1, 1'b0, 2'd3, 10'd0,   4'b0000});
    vecs.push_back('{3,   5,   1'b1, 1'b0, 2'd0, 10'd0,   4'b0001});
    vecs.push_back('{3,   8,   1'b1, 1'b0, 2'd0, 10'd3,   4'b1110});
    vecs.push_back('{3,   13,  1'b1, 1'b0, 2'd0, 10'd8,   4'b0000});
    vecs.push_back('{3,   14,  1'b1, 1'b0, 2'd3, 10'd0,   4'b0000});
    vecs.push_back('{3,   17,  1'b1, 1'b0, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{3,   18,  1'b1, 1'b1, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{3,   19,  1'b0, 1'b0, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{0,   5,   1'b1, 1'b0, 2'd3, 10'd0,   4'b0000});
    vecs.push_back('{0,   9,   1'b1, 1'b1, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{0,   10,  1'b0, 1'b0, 2'd0, 10'd0,   4'b0000});
    vecs.push_back('{255, 262, 1'b1, 1'b0, 2'd0, 10'd257, 4'b1000});

    foreach (vecs[i]) begin
      start_pass(vecs[i].k);
      for (int c = 1; c < vecs[i].cyc; c++) @(negedge clk);
      check($sformatf("vec%0d_k%0d_c%0d", i, vecs[i].k, vecs[i].cyc),
            64'({busy, done, c_idx, step, a_mask}),
            64'({vecs[i].busy, vecs[i].done, vecs[i].cidx, vecs[i].step, vecs[i].am}));
      wait_idle();
    end

    // Random full passes, every cycle against the model, some aborted.
    for (int t = 0; t < 12; t++) begin
      k    = (t == 0) ? 0 : $urandom_range(0, 12);
      len  = (k > 0) ? k + 2 * DIM - 2 : 0;
      n_ab = (t % 3 == 2) ? $urandom_range(1, 2 * DIM + len + 1) : 1000;
      start_pass(k);
      for (int n = 1; n <= 2 * DIM + len + 3; n++) begin
        exp_o = (n > n_ab) ? obs_t'('0) : model(k, n);
        check($sformatf("rand%0d_k%0d_n%0d", t, k, n), 64'(sample()), 64'(exp_o));
        abort = (n == n_ab);
        @(negedge clk);
      end
      abort = 1'b0;
    end

    // Abort at COMPUTE step 4 (cycle 9), then a clean pass.
    start_pass(3);
    for (int c = 1; c < 9; c++) @(negedge clk);
    check("abort_step", 64'(step), 64'(4));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'(sample()), 64'(obs_t'('0)));
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check("abort_no_done", 64'(seen), 64'(0));
    start_pass(3);
    for (int n = 1; n <= 19; n++) begin
      check($sformatf("post_abort_n%0d", n), 64'(sample()), 64'(model(3, n)));
      @(negedge clk);
    end

    // Asynchronous reset pulse in the second DRAIN cycle of a K=2 pass.
    start_pass(2);
    for (int c = 1; c < 13; c++) @(negedge clk);
    check("pre_reset_drain", 64'(out_valid), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(sample()), 64'(obs_t'('0)));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check("reset_needs_start", 64'(seen), 64'(0));

    // start held high with K=1: 16-cycle passes separated by one IDLE cycle.
    @(negedge clk);
    start = 1'b1;
    cfg_k = KW'(1);
    @(negedge clk);
    for (int n = 1; n <= 51; n++) begin
      m = ((n - 1) % 17) + 1;
      check($sformatf("b2b_n%0d", n), 64'(sample()), 64'(model(1, m)));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
